tmds_channel_encoder: RTL and testbench



---
 rtl/tmds_channel_encoder.sv | 186 ++++++++++++++++++
 tb/tb_tmds_channel_encoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_encoder.sv
// ----------------------------------------------------------------------------
// tmds_channel_encoder
// One TMDS channel: 8b/10b transition-minimising encode with running-disparity
// DC balance. Emits one 10-bit symbol per pixel clock, bit 0 sent first.
// Pipeline: optional input register, transition-minimisation stage, and a
// DC-balance stage whose outputs come straight from flops.
// ----------------------------------------------------------------------------
module tmds_channel_encoder #(
    parameter logic PIPE_IN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        data_i,
    input  logic              de_i,
    input  logic [1:0]        ctrl_i,
    output logic [9:0]        tmds_o,
    output logic signed [4:0] disp_o
);

    // Control-period symbols, indexed by {C1,C0}.
    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: optional input register
    // ------------------------------------------------------------------
    logic [7:0] s1_data;
    logic       s1_de;
    logic [1:0] s1_ctrl;

    generate
        if (PIPE_IN) begin : g_pipe_in
            logic [7:0] data_s1_reg;
            logic       de_s1_reg;
            logic [1:0] ctrl_s1_reg;

            // Capture the raw pixel inputs once per clock.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    data_s1_reg <= 8'd0;
                    de_s1_reg   <= 1'b0;
                    ctrl_s1_reg <= 2'b00;
                end else begin
                    data_s1_reg <= data_i;
                    de_s1_reg   <= de_i;
                    ctrl_s1_reg <= ctrl_i;
                end
            end

            assign s1_data = data_s1_reg;
            assign s1_de   = de_s1_reg;
            assign s1_ctrl = ctrl_s1_reg;
        end else begin : g_no_pipe_in
            assign s1_data = data_i;
            assign s1_de   = de_i;
            assign s1_ctrl = ctrl_i;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 2: transition minimisation
    // ------------------------------------------------------------------
    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] qm_next;
    logic [3:0] n1q_next;

    assign n1d      = popcount8(s1_data);
    // XNOR chaining is chosen for ones-heavy words to cut transitions.
    assign use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !s1_data[0]);

    // Build q_m as an XOR or XNOR running chain over the data bits.
    always_comb begin
        qm_next    = 9'd0;
        qm_next[0] = s1_data[0];
        for (int i = 1; i < 8; i++) begin
            if (use_xnor) begin
                qm_next[i] = ~(qm_next[i-1] ^ s1_data[i]);
            end else begin
                qm_next[i] = qm_next[i-1] ^ s1_data[i];
            end
        end
        qm_next[8] = ~use_xnor;
    end

    assign n1q_next = popcount8(qm_next[7:0]);

    logic [8:0] qm_reg;
    logic [3:0] n1q_reg;
    logic [3:0] n0q_reg;
    logic       de_s2_reg;
    logic [1:0] ctrl_s2_reg;

    // Register q_m with its ones/zeros counts so stage 3 only adds.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            qm_reg      <= 9'd0;
            n1q_reg     <= 4'd0;
            n0q_reg     <= 4'd8;
            de_s2_reg   <= 1'b0;
            ctrl_s2_reg <= 2'b00;
        end else begin
            qm_reg      <= qm_next;
            n1q_reg     <= n1q_next;
            n0q_reg     <= 4'd8 - n1q_next;
            de_s2_reg   <= s1_de;
            ctrl_s2_reg <= s1_ctrl;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: DC balance
    // ------------------------------------------------------------------
    logic signed [4:0] cnt_reg;
    logic signed [4:0] cnt_next;
    logic [9:0]        tmds_reg;
    logic [9:0]        tmds_next;

    logic signed [4:0] n1_s;
    logic signed [4:0] n0_s;
    logic signed [4:0] diff_s;      // n1q - n0q, always within +/-8
    logic signed [4:0] bias_s;      // 2 when q_m[8] is set, else 0
    logic              balanced;
    logic              invert_data;

    assign n1_s   = $signed({1'b0, n1q_reg});
    assign n0_s   = $signed({1'b0, n0q_reg});
    assign diff_s = n1_s - n0_s;
    assign bias_s = qm_reg[8] ? 5'sd2 : 5'sd0;

    assign balanced    = (cnt_reg == 5'sd0) || (n1q_reg == n0q_reg);
    // Invert when the word would push the disparity further the same way.
    assign invert_data = ((cnt_reg > 5'sd0) && (n1q_reg > n0q_reg)) ||
                         ((cnt_reg < 5'sd0) && (n0q_reg > n1q_reg));

    // Choose the outgoing symbol and the next running disparity.
    always_comb begin
        tmds_next = CTRL_00;
        cnt_next  = 5'sd0;
        if (!de_s2_reg) begin
            case (ctrl_s2_reg)
                2'b00:   tmds_next = CTRL_00;
                2'b01:   tmds_next = CTRL_01;
                2'b10:   tmds_next = CTRL_10;
                default: tmds_next = CTRL_11;
            endcase
            cnt_next = 5'sd0;
        end else if (balanced) begin
            tmds_next = {~qm_reg[8], qm_reg[8],
                         qm_reg[8] ? qm_reg[7:0] : ~qm_reg[7:0]};
            cnt_next  = qm_reg[8] ? (cnt_reg + diff_s) : (cnt_reg - diff_s);
        end else if (invert_data) begin
            tmds_next = {1'b1, qm_reg[8], ~qm_reg[7:0]};
            cnt_next  = cnt_reg + bias_s - diff_s;
        end else begin
            tmds_next = {1'b0, qm_reg[8], qm_reg[7:0]};
            cnt_next  = cnt_reg + diff_s - (5'sd2 - bias_s);
        end
    end

    // Output symbol and disparity leave the block directly from flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmds_reg <= CTRL_00;
            cnt_reg  <= 5'sd0;
        end else begin
            tmds_reg <= tmds_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign tmds_o = tmds_reg;
    assign disp_o = cnt_reg;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// ----------------------------------------------------------------------------
// tb_tmds_channel_encoder
// Drives a 3-stage and a 2-stage encoder with identical stimulus; expected
// symbols are queued at drive time and popped when each pipeline delivers.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tmds_channel_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       de;
    logic [1:0] ctrl;
    logic [9:0] tmds3;
    logic [4:0] disp3;
    logic [9:0] tmds2;
    logic [4:0] disp2;

    tmds_channel_encoder #(.PIPE_IN(1'b1)) dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .data_i(data),
        .de_i  (de),
        .ctrl_i(ctrl),
        .tmds_o(tmds3),
        .disp_o(disp3)
    );

    tmds_channel_encoder #(.PIPE_IN(1'b0)) dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .data_i(data),
        .de_i  (de),
        .ctrl_i(ctrl),
        .tmds_o(tmds2),
        .disp_o(disp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] tmds;
        logic [4:0] disp;
        logic       de;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
        logic [9:0] tmds;
        logic [4:0] disp;
    } vec_t;

    exp_t q3[$];
    exp_t q2[$];
    vec_t vecs[14];

    int         compared = 0;
    int         failed   = 0;
    int         txn      = 0;
    int         model_cnt = 0;
    logic [9:0] prev_t2;

    // Recover the 8-bit word a TMDS receiver would decode.
    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    // Behavioural encoder using integer disparity.
    task automatic model_step(input logic m_de, input logic [1:0] m_ctrl,
                              input logic [7:0] d, output logic [9:0] sym);
        logic [8:0] qm;
        int n1, n0, ones_in;
        if (!m_de) begin
            case (m_ctrl)
                2'b00:   sym = 10'h354;
                2'b01:   sym = 10'h0AB;
                2'b10:   sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
            model_cnt = 0;
        end else begin
            ones_in = 0;
            for (int i = 0; i < 8; i++) ones_in += int'(d[i]);
            qm[0] = d[0];
            if (ones_in > 4 || (ones_in == 4 && d[0] == 1'b0)) begin
                for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
                qm[8] = 1'b0;
            end else begin
                for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
                qm[8] = 1'b1;
            end
            n1 = 0;
            for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
            n0 = 8 - n1;
            if (model_cnt == 0 || n1 == n0) begin
                sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                model_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
            end else if ((model_cnt > 0 && n1 > n0) || (model_cnt < 0 && n0 > n1)) begin
                sym = {1'b1, qm[8], ~qm[7:0]};
                model_cnt += 2 * int'(qm[8]) + (n0 - n1);
            end else begin
                sym = {1'b0, qm[8], qm[7:0]};
                model_cnt += (n1 - n0) - 2 * int'(!qm[8]);
            end
        end
    endtask

    task automatic check_one(input string name, input logic [9:0] t,
                             input logic [4:0] d, input exp_t e);
        logic [7:0] dec;
        compared++;
        if (t !== e.tmds) begin
            failed++;
            $display("FAIL %s tmds: got %h required %h", name, t, e.tmds);
        end
        compared++;
        if (d !== e.disp) begin
            failed++;
            $display("FAIL %s disp: got %0d required %0d", name, $signed(d), $signed(e.disp));
        end
        compared++;
        if ($signed(d) > 10 || $signed(d) < -10) begin
            failed++;
            $display("FAIL %s disp_range: got %0d required |disp|<=10", name, $signed(d));
        end
        if (e.de) begin
            dec = decode(t);
            compared++;
            if (dec !== e.data) begin
                failed++;
                $display("FAIL %s decode: got %h required %h", name, dec, e.data);
            end
        end
    endtask

    // Compare whatever both pipelines deliver at this falling edge.
    task automatic sample();
        exp_t e;
        if (q3.size() >= 3) begin
            e = q3.pop_front();
            check_one("lat3", tmds3, disp3, e);
        end
        if (q2.size() >= 2) begin
            e = q2.pop_front();
            check_one("lat2", tmds2, disp2, e);
        end
        compared++;
        if (tmds3 !== prev_t2) begin
            failed++;
            $display("FAIL offset: got %h required %h", tmds3, prev_t2);
        end
        prev_t2 = tmds2;
        txn++;
        $display("txn %0d: tmds3=%h disp3=%0d tmds2=%h disp2=%0d",
                 txn, tmds3, $signed(disp3), tmds2, $signed(disp2));
    endtask

    task automatic cycle(input logic d_de, input logic [1:0] d_ctrl,
                         input logic [7:0] d_data, input logic have_exp,
                         input logic [9:0] et, input logic [4:0] ed);
        logic [9:0] sym;
        exp_t e;
        @(negedge clk);
        sample();
        de   = d_de;
        ctrl = d_ctrl;
        data = d_data;
        model_step(d_de, d_ctrl, d_data, sym);
        e.tmds = have_exp ? et : sym;
        e.disp = have_exp ? ed : model_cnt[4:0];
        e.de   = d_de;
        e.data = d_data;
        q3.push_back(e);
        q2.push_back(e);
    endtask

    task automatic reset_release();
        exp_t r;
        de   = 1'b0;
        ctrl = 2'b00;
        data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q3.delete();
        q2.delete();
        r.tmds = 10'h354;
        r.disp = 5'd0;
        r.de   = 1'b0;
        r.data = 8'h00;
        repeat (3) q3.push_back(r);
        repeat (2) q2.push_back(r);
        model_cnt = 0;
        prev_t2   = 10'h354;
    endtask

    task automatic run_table();
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].de, vecs[i].ctrl, vecs[i].data, 1'b1,
                  vecs[i].tmds, vecs[i].disp);
        end
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), 1'b0, 10'h0, 5'd0);
        end
    endtask

    initial begin
        // {de, ctrl, data, expected tmds, expected disp}
        vecs[0]  = '{1'b0, 2'b01, 8'h00, 10'h0AB, 5'h00};
        vecs[1]  = '{1'b0, 2'b10, 8'h00, 10'h154, 5'h00};
        vecs[2]  = '{1'b0, 2'b11, 8'h00, 10'h2AB, 5'h00};
        vecs[3]  = '{1'b0, 2'b00, 8'h00, 10'h354, 5'h00};
        vecs[4]  = '{1'b1, 2'b00, 8'h00, 10'h100, 5'h18};  // -8
        vecs[5]  = '{1'b1, 2'b00, 8'h00, 10'h3FF, 5'h02};  // +2
        vecs[6]  = '{1'b1, 2'b00, 8'h00, 10'h100, 5'h1A};  // -6
        vecs[7]  = '{1'b0, 2'b00, 8'h00, 10'h354, 5'h00};
        vecs[8]  = '{1'b1, 2'b00, 8'hFF, 10'h200, 5'h18};  // XNOR path, -8
        vecs[9]  = '{1'b1, 2'b00, 8'h00, 10'h3FF, 5'h02};
        vecs[10] = '{1'b0, 2'b11, 8'h00, 10'h2AB, 5'h00};  // blanking clears cnt
        vecs[11] = '{1'b1, 2'b00, 8'h00, 10'h100, 5'h18};  // restarts from cnt=0
        vecs[12] = '{1'b0, 2'b00, 8'h00, 10'h354, 5'h00};
        vecs[13] = '{1'b1, 2'b11, 8'hFF, 10'h200, 5'h18};  // ctrl ignored on de rise

        rst     = 1'b1;
        prev_t2 = 10'h354;
        reset_release();

        run_table();
        run_random(4000);

        // Mid-stream reset: outputs must snap back without a clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (tmds3 !== 10'h354) begin
            failed++;
            $display("FAIL async_rst tmds3: got %h required 354", tmds3);
        end
        compared++;
        if (disp3 !== 5'd0) begin
            failed++;
            $display("FAIL async_rst disp3: got %0d required 0", $signed(disp3));
        end
        compared++;
        if (tmds2 !== 10'h354) begin
            failed++;
            $display("FAIL async_rst tmds2: got %h required 354", tmds2);
        end
        compared++;
        if (disp2 !== 5'd0) begin
            failed++;
            $display("FAIL async_rst disp2: got %0d required 0", $signed(disp2));
        end
        reset_release();

        run_table();
        run_random(4000);
        // Drain the pipelines with blanking so every queued entry is checked.
        for (int i = 0; i < 4; i++) cycle(1'b0, 2'b00, 8'h00, 1'b0, 10'h0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
